// File: rtl/hit_out_buffer_if.sv
// hit_out_buffer_if: rast hit input bus, halt back-pressure and frame-buffer write bus
// Stats ports exist only when HIT_OUT_BUFFER_STATS_EN is defined.
interface hit_out_buffer_if #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic [1:0][SIGFIG-1:0]        screen_RnnnnS;
  logic [AXIS-1:0][SIGFIG-1:0]   hit_R18S;
  logic [COLORS-1:0][SIGFIG-1:0] color_R18U;
  logic                          hit_valid_R18H;
  logic                          halt_RnnnnL;
  logic                          wr_valid_R19H;
  logic                          wr_ready_R19H;
  logic [SIGFIG-RADIX-1:0]       wr_x_R19U;
  logic [SIGFIG-RADIX-1:0]       wr_y_R19U;
  logic [SIGFIG-1:0]             wr_z_R19S;
  logic [COLORS-1:0][SIGFIG-1:0] wr_color_R19U;
  logic                          overflow_R19H;
`ifdef HIT_OUT_BUFFER_STATS_EN
  logic [31:0]                   hits_in_R19U;
  logic [31:0]                   clipped_R19U;
  logic [31:0]                   dropped_R19U;
`else
`endif
  modport slave (
    input  screen_RnnnnS, hit_R18S, color_R18U, hit_valid_R18H, wr_ready_R19H,
    output halt_RnnnnL, wr_valid_R19H, wr_x_R19U, wr_y_R19U, wr_z_R19S, wr_color_R19U, overflow_R19H
`ifdef HIT_OUT_BUFFER_STATS_EN
    , hits_in_R19U, clipped_R19U, dropped_R19U
`endif
  );
  modport master (
    output screen_RnnnnS, hit_R18S, color_R18U, hit_valid_R18H, wr_ready_R19H,
    input  halt_RnnnnL, wr_valid_R19H, wr_x_R19U, wr_y_R19U, wr_z_R19S, wr_color_R19U, overflow_R19H
`ifdef HIT_OUT_BUFFER_STATS_EN
    , hits_in_R19U, clipped_R19U, dropped_R19U
`endif
  );
endinterface

// File: rtl/hit_out_buffer.sv
// hit_out_buffer: screen-clip rast hits, convert to pixel coords, queue in a FIFO and drain over valid/ready
// HIT_OUT_BUFFER_STATS_EN adds saturating hits_in/clipped/dropped counters.
module hit_out_buffer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 16,
  parameter int SKID   = 12
) (
  input logic             clk,
  input logic             rst,
  hit_out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = SIGFIG - RADIX;
  typedef struct packed {
    logic [PW-1:0]                 x;
    logic [PW-1:0]                 y;
    logic [SIGFIG-1:0]             z;
    logic [COLORS-1:0][SIGFIG-1:0] c;
  } entry_t;
  if (SKID >= DEPTH) begin : g_skid_chk
    $error("hit_out_buffer: SKID must be less than DEPTH");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("hit_out_buffer: DEPTH must be a power of 2 and at least 4");
  end
  entry_t                   mem [DEPTH];
  entry_t                   head;
  logic [AW-1:0]            rd_ptr, wr_ptr;
  logic [AW:0]              count, count_next;
  logic signed [SIGFIG-1:0] hx, hy;
  logic                     in_bounds, push_req, pop, push, drop;
  always_comb begin
    hx         = bus.hit_R18S[0];
    hy         = bus.hit_R18S[1];
    in_bounds  = !hx[SIGFIG-1] && !hy[SIGFIG-1] &&
                 hx < $signed(bus.screen_RnnnnS[0]) && hy < $signed(bus.screen_RnnnnS[1]);
    push_req   = bus.hit_valid_R18H && in_bounds;
    pop        = bus.wr_valid_R19H && bus.wr_ready_R19H;
    push       = push_req && (count < (AW+1)'(DEPTH) || pop);
    drop       = push_req && !push;
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  assign head              = mem[rd_ptr];
  assign bus.wr_valid_R19H = count != '0;
  assign bus.wr_x_R19U     = head.x;
  assign bus.wr_y_R19U     = head.y;
  assign bus.wr_z_R19S     = head.z;
  assign bus.wr_color_R19U = head.c;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{x: hx[SIGFIG-1:RADIX], y: hy[SIGFIG-1:RADIX], z: bus.hit_R18S[2], c: bus.color_R18U};
  // halt looks at the post-update occupancy so rast sees it in time to cover SKID more hits
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      bus.halt_RnnnnL   <= 1'b1;
      bus.overflow_R19H <= 1'b0;
    end else begin
      rd_ptr            <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr            <= push ? wr_ptr + 1'b1 : wr_ptr;
      count             <= count_next;
      bus.halt_RnnnnL   <= ((AW+1)'(DEPTH) - count_next) > (AW+1)'(SKID);
      bus.overflow_R19H <= bus.overflow_R19H | drop;
    end
`ifdef HIT_OUT_BUFFER_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      bus.hits_in_R19U <= '0;
      bus.clipped_R19U <= '0;
      bus.dropped_R19U <= '0;
    end else begin
      if (bus.hit_valid_R18H && bus.hits_in_R19U != '1) bus.hits_in_R19U <= bus.hits_in_R19U + 32'd1;
      if (bus.hit_valid_R18H && !in_bounds && bus.clipped_R19U != '1) bus.clipped_R19U <= bus.clipped_R19U + 32'd1;
      if (drop && bus.dropped_R19U != '1) bus.dropped_R19U <= bus.dropped_R19U + 32'd1;
    end
`else
`endif
endmodule
